adder_bist_ctrl: RTL and testbench

ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

---
 rtl/adder_bist_ctrl.sv | 106 ++++++++++
 tb/tb_adder_bist_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive sweep BIST controller for a WIDTH-bit adder
// Optional stop-on-first-mismatch behaviour: ADDER_BIST_STOP_ON_FAIL_EN
module adder_bist_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int VW = 2*WIDTH + 1;
  localparam int CW = 2*WIDTH + 2;
  localparam logic [VW-1:0] VEC_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t          state;
  logic [VW-1:0]   vec;
  logic [WIDTH:0]  expected;
  logic            mismatch;
  logic            last_vec;
  logic            finish;

  // vec is laid out {cin,b,a} so a plain increment gives a-fastest ordering
  assign {cin, b, a} = vec;
  assign expected    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign mismatch    = ({cout, sum} != expected);
  assign last_vec    = &vec;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign finish = abort | last_vec | mismatch;
`else
  assign finish = abort | last_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec      <= '0;
            error    <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
            busy     <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          // a mismatch is recorded even when abort arrives in the same cycle
          if (mismatch) begin
            error <= 1'b1;
            if (!(&err_cnt)) err_cnt <= err_cnt + CNT_ONE;
            if (!error) fail_vec <= vec;
          end
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec   <= vec + VEC_ONE;
            state <= APPLY;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - self-checking bench for adder_bist_ctrl with a fault-injectable adder
module tb_adder_bist_ctrl;

  localparam int W  = 4;
  localparam int NV = 1 << (2*W + 1);

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [W-1:0]    a, b, sum;
  logic            cin, cout, busy, done, error;
  logic [2*W+1:0]  err_cnt;
  logic [2*W:0]    fail_vec;

  int   fault_mode = 0;
  logic bad [0:NV-1];
  int   checks = 0;
  int   failures = 0;

  adder_bist_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .error(error),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // adder under test: 0 good, 1 cout stuck-at-0, 2 sum[0] stuck-at-0, 3 sum[0] flipped on bad[] vectors
  function automatic logic [W:0] fault_adder(input logic [2*W:0] v);
    logic [W:0] r;
    r = {1'b0, v[W-1:0]} + {1'b0, v[2*W-1:W]} + {{W{1'b0}}, v[2*W]};
    case (fault_mode)
      1: r[W] = 1'b0;
      2: r[0] = 1'b0;
      3: if (bad[v]) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  assign {cout, sum} = fault_adder({cin, b, a});

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the vector list in sweep order with plain arithmetic
  task automatic model(input int abort_k, input bit abort_apply, input bit stop_on_fail,
                       output int cnt, output int fv, output int last);
    int n;
    int good;
    n    = (abort_k < 0) ? NV : (abort_apply ? abort_k : abort_k + 1);
    cnt  = 0;
    fv   = 0;
    last = (abort_k < 0) ? NV - 1 : abort_k;
    for (int v = 0; v < n; v++) begin
      good = (v % 16) + ((v / 16) % 16) + (v / 256);
      if (int'(fault_adder(v[2*W:0])) != good) begin
        if (cnt == 0) fv = v;
        cnt++;
        if (stop_on_fail) begin
          last = v;
          break;
        end
      end
    end
  endtask

  // Runs one sweep; abort_k >= 0 aborts in CHECK (or APPLY) of that vector index
  task automatic run(input string nm, input int abort_k, input bit abort_apply, output int lat);
    int e;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, "_busy"}, int'(busy), 1);
    e = 0;
    while (!done && e < 3000) begin
      if (abort_k >= 0 && e == (abort_apply ? 2*abort_k : 2*abort_k + 1)) abort = 1'b1;
      tick;
      abort = 1'b0;
      e++;
    end
    if (e >= 3000) chk({nm, "_timeout"}, e, -1);
    lat = e;
  endtask

  task automatic post_checks(input string nm, input int cnt, input int fv, input int vec);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    tick;
    chk({nm, "_done_one_cycle"}, int'(done), 0);
    tick;
    chk({nm, "_err_cnt"}, int'(err_cnt), cnt);
    chk({nm, "_fail_vec"}, int'(fail_vec), fv);
    chk({nm, "_error"}, int'(error), int'(cnt != 0));
    chk({nm, "_vec_held"}, int'({cin, b, a}), vec);
  endtask

  typedef struct {
    int mode;
    int abort_k;
    bit abort_apply;
    int lat;
    int cnt;
    int fv;
    int vec;
  } vec_t;

  vec_t tbl [8];
  bit   stop_en;

  initial begin
    int lat, cnt, fv, last, ak;
    bit ap;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    stop_en = 1'b1;
    tbl[0] = '{0, -1, 0, 1024,   0,    0, 511};
    tbl[1] = '{1, -1, 0,   64,   1, 'h1F, 'h1F};
    tbl[2] = '{2, -1, 0,    4,   1,    1,   1};
    tbl[3] = '{0,  9, 0,   20,   0,    0,   9};
    tbl[4] = '{2,  9, 0,    4,   1,    1,   1};
    tbl[5] = '{1, 39, 0,   64,   1, 'h1F, 'h1F};
    tbl[6] = '{0,  5, 1,   11,   0,    0,   5};
    tbl[7] = '{2,  5, 1,    4,   1,    1,   1};
`else
    stop_en = 1'b0;
    tbl[0] = '{0, -1, 0, 1024,   0,    0, 511};
    tbl[1] = '{1, -1, 0, 1024, 256, 'h1F, 511};
    tbl[2] = '{2, -1, 0, 1024, 256,    1, 511};
    tbl[3] = '{0,  9, 0,   20,   0,    0,   9};
    tbl[4] = '{2,  9, 0,   20,   5,    1,   9};
    tbl[5] = '{1, 39, 0,   80,   1, 'h1F,  39};
    tbl[6] = '{0,  5, 1,   11,   0,    0,   5};
    tbl[7] = '{2,  5, 1,   11,   2,    1,   5};
`endif
    for (int i = 0; i < NV; i++) bad[i] = 1'b0;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_vec", int'({cin, b, a}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_fail_vec", int'(fail_vec), 0);

    abort = 1'b1;
    tick;
    tick;
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_done", int'(done), 0);

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      fault_mode = tbl[i].mode;
      run(nm, tbl[i].abort_k, tbl[i].abort_apply, lat);
      chk({nm, "_latency"}, lat, tbl[i].lat);
      post_checks(nm, tbl[i].cnt, tbl[i].fv, tbl[i].vec);
    end

    for (int r = 0; r < 4; r++) begin
      string nm;
      nm = $sformatf("rnd%0d", r);
      fault_mode = 3;
      for (int i = 0; i < NV; i++) bad[i] = ($urandom_range(0, 15) == 0);
      ak = (r == 0) ? -1 : int'($urandom_range(0, NV - 1));
      ap = (r == 3);
      model(ak, ap, stop_en, cnt, fv, last);
      run(nm, ak, ap, lat);
      post_checks(nm, cnt, fv, last);
    end

    // start held high throughout, reset mid-sweep
    fault_mode = 0;
    start = 1'b1;
    tick;
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 300; i++) begin
        tick;
        if (done) seen_done++;
      end
      chk("hold_start_no_done", seen_done, 0);
      chk("hold_start_vec", int'({cin, b, a}), 150);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      start = 1'b0;
      chk("midrst_vec", int'({cin, b, a}), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_err_cnt", int'(err_cnt), 0);
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
        tick;
        if (done || busy) seen_done++;
      end
      chk("midrst_quiet", seen_done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
